pe_acc_drain: RTL and testbench
===============================

// Module: pe_acc_drain
// PURPOSE
//  Parametrised systolic-array processing element, the successor to the fixed 8b/32b PE.
//  - Operands flow west->east (a) and north->south (b) with a valid tag; MAC occurs only on valid data.
//  - Adds a double-buffered result register on a daisy-chained drain path, so a finished tile
//    shifts out while the next tile accumulates.
//  - Adds signed/unsigned mode and a sticky overflow flag.
//  - Instantiated NxN by the array wrapper; drain chains run along each row to the array edge.
// PARAMETERS
//  DATA_W  8   operand width (a, b)
//  ACC_W   32  accumulator / result width; must be >= 2*DATA_W
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  clear       in   1       start new tile: next accumulate restarts from zero
//  signed_mode in   1       1: operands signed; 0: operands unsigned
//  in_valid    in   1       a_in/b_in valid this cycle
//  a_in        in   DATA_W  west operand
//  b_in        in   DATA_W  north operand
//  a_out       out  DATA_W  registered a_in to east neighbour
//  b_out       out  DATA_W  registered b_in to south neighbour
//  out_valid   out  1       registered in_valid to neighbours
//  acc         out  ACC_W   live accumulator
//  ovf         out  1       sticky overflow since last clear
//  res_load    in   1       copy acc into result register (tile done)
//  res_shift   in   1       shift drain chain one position
//  res_in      in   ACC_W   result from upstream PE on drain chain
//  res_vin     in   1       valid tag accompanying res_in
//  res_out     out  ACC_W   result register, to downstream PE / array edge
//  res_vout    out  1       res_out holds a valid, undrained result
// BEHAVIOUR
//  - Reset: a_out, b_out, acc, res_out = 0; out_valid, ovf, res_vout = 0. Async assert, sync release.
//  - Forwarding: a_out/b_out/out_valid <= a_in/b_in/in_valid every cycle, independent of clear/load.
//    Latency 1, no stall.
//  - Product: sign- (signed_mode=1) or zero- (signed_mode=0) extend a_in and b_in to ACC_W, then multiply.
//    The full 2*DATA_W product is exact.
//  - Accumulator update, priority order:
//      clear & in_valid -> acc <= product, ovf <= 0   (the first product of a tile is never lost)
//      clear & !in_valid -> acc <= 0, ovf <= 0
//      in_valid          -> acc <= acc + product
//      else              -> acc holds
//  - Overflow: set when the ACC_W add overflows. Signed mode: operand signs equal, result sign differs.
//    Unsigned mode: carry out. Sticky until clear or rst.
//  - Drain register, priority order:
//      res_load  -> res_out <= acc (value BEFORE this cycle's update), res_vout <= 1
//      res_shift -> res_out <= res_in, res_vout <= res_vin
//      else      -> hold
//  - res_load with clear in the same cycle is legal: the old tile is captured and the new tile starts.
//    This is back-to-back tiles with zero bubble.
//  - res_load with res_shift in the same cycle: load wins, and the upstream value is dropped.
//    The controller must not issue this.
//  - A chain of N PEs drains in N res_shift cycles. The first PE ties res_in=0, res_vin=0.
//  - rst mid-tile or mid-drain: all state cleared immediately; partial results discarded.
// CONFIGURATION
//  PE_SAT_EN defined:
//    - on overflow, acc clamps instead of wrapping, and ovf still sets.
//    - signed clamp: max 2^(ACC_W-1)-1 / min -2^(ACC_W-1). Unsigned clamp: 2^ACC_W-1.
//    - further adds continue from the clamped value.
//  PE_SAT_EN undefined:
//    - modulo-2^ACC_W wrap; ovf is still reported.
// TESTING
//  1. rst=1 mid-run -> all outputs 0 same cycle; after release, a_in=5 valid -> a_out=5, out_valid=1 next cycle.
//  2. Signed, clear+valid a=-3 b=4, then valid a=2 b=7 -> acc=-12, then acc=2; ovf=0.
//  3. Unsigned a=b=255 for 3 valid cycles -> acc=195075. Signed, same bits -> acc=3 (3 x (-1)x(-1)).
//  4. in_valid=0 with a=9 b=9 for 4 cycles -> acc unchanged; out_valid=0.
//  5. Chain of 4 PEs, accs 10/20/30/40: res_load+clear, then 4 res_shift -> edge sees 40,30,20,10.
//     res_vout falls to 0 after the 4th shift. New tile accumulates during the drain.
//  6. ACC_W=16 signed, acc=32767, add 1:
//     - without PE_SAT_EN -> acc=-32768, ovf=1.
//     - with PE_SAT_EN -> acc=32767, ovf=1.
//     - clear -> ovf=0.

Source files
------------

// File: rtl/pe_acc_drain_if.sv
// Bus bundle for one systolic processing element: operand forwarding,
// accumulator status and the daisy-chained result drain.
// master = array controller / neighbour side, slave = the PE itself.
interface pe_acc_drain_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic              clear;
    logic              signed_mode;
    logic              in_valid;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              out_valid;
    logic [ACC_W-1:0]  acc;
    logic              ovf;
    logic              res_load;
    logic              res_shift;
    logic [ACC_W-1:0]  res_in;
    logic              res_vin;
    logic [ACC_W-1:0]  res_out;
    logic              res_vout;

    modport master (
        output clear, signed_mode, in_valid, a_in, b_in,
        output res_load, res_shift, res_in, res_vin,
        input  a_out, b_out, out_valid, acc, ovf, res_out, res_vout
    );

    modport slave (
        input  clear, signed_mode, in_valid, a_in, b_in,
        input  res_load, res_shift, res_in, res_vin,
        output a_out, b_out, out_valid, acc, ovf, res_out, res_vout
    );
endinterface

// File: rtl/pe_acc_drain.sv
// Systolic-array processing element with signed/unsigned MAC, sticky
// overflow flag and a double-buffered result register on a drain chain.
// Optional feature: define PE_SAT_EN to clamp the accumulator on overflow
// instead of wrapping modulo 2^ACC_W (ovf is reported either way).
module pe_acc_drain #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input logic            clk,
    input logic            rst,
    pe_acc_drain_if.slave  bus
);
    // Multiplier width: operands carry one extra bit so signed and unsigned
    // operands share a single signed multiplier.
    localparam int PW = (ACC_W > 2*DATA_W+2) ? ACC_W : 2*DATA_W+2;

    logic signed [DATA_W:0] a_ext;
    logic signed [DATA_W:0] b_ext;
    logic signed [PW-1:0]   prod_wide;
    logic [ACC_W-1:0]       product;
    logic [ACC_W:0]         sum_ext;
    logic [ACC_W-1:0]       sum;
    logic                   ovf_add;

    logic [DATA_W-1:0]      a_reg;
    logic [DATA_W-1:0]      b_reg;
    logic                   valid_reg;
    logic [ACC_W-1:0]       acc_reg;
    logic [ACC_W-1:0]       acc_next;
    logic                   ovf_reg;
    logic                   ovf_next;
    logic [ACC_W-1:0]       res_reg;
    logic                   res_valid_reg;

    // Extra top bit is the sign in signed mode and zero in unsigned mode.
    assign a_ext = {bus.signed_mode & bus.a_in[DATA_W-1], bus.a_in};
    assign b_ext = {bus.signed_mode & bus.b_in[DATA_W-1], bus.b_in};

    // Exact product; the low ACC_W bits are already correctly extended.
    assign prod_wide = PW'(a_ext) * PW'(b_ext);
    assign product   = prod_wide[ACC_W-1:0];

    generate
        if (PW > ACC_W) begin : g_prod_trim
            // Bits above ACC_W only repeat the sign and carry no information.
            logic unused_prod_hi;
            assign unused_prod_hi = ^prod_wide[PW-1:ACC_W];
        end
    endgenerate

    assign sum_ext = {1'b0, acc_reg} + {1'b0, product};
    assign sum     = sum_ext[ACC_W-1:0];

    // Signed: operands agree in sign but the result does not. Unsigned: carry out.
    assign ovf_add = bus.signed_mode
                   ? ((acc_reg[ACC_W-1] == product[ACC_W-1]) && (sum[ACC_W-1] != acc_reg[ACC_W-1]))
                   : sum_ext[ACC_W];

`ifdef PE_SAT_EN
    logic [ACC_W-1:0] sat_val;
    // Clamp direction follows the accumulator sign: signed overflow can only
    // move away from zero in the direction of the current value.
    assign sat_val = !bus.signed_mode ? {ACC_W{1'b1}}
                   : acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                   :                    {1'b0, {(ACC_W-1){1'b1}}};
`endif

    // Accumulator next state: clear has priority and keeps a coincident product.
    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (bus.clear) begin
            ovf_next = 1'b0;
            acc_next = bus.in_valid ? product : '0;
        end else if (bus.in_valid) begin
            ovf_next = ovf_reg | ovf_add;
`ifdef PE_SAT_EN
            acc_next = ovf_add ? sat_val : sum;
`else
            acc_next = sum;
`endif
        end
    end

    // Operand forwarding to east/south neighbours, one cycle, never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            a_reg     <= bus.a_in;
            b_reg     <= bus.b_in;
            valid_reg <= bus.in_valid;
        end
    end

    // Accumulator and sticky overflow state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
        end
    end

    // Drain register: load captures the pre-update accumulator so a tile can
    // finish and the next one start in the same cycle; load beats shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_reg       <= '0;
            res_valid_reg <= 1'b0;
        end else if (bus.res_load) begin
            res_reg       <= acc_reg;
            res_valid_reg <= 1'b1;
        end else if (bus.res_shift) begin
            res_reg       <= bus.res_in;
            res_valid_reg <= bus.res_vin;
        end
    end

    assign bus.a_out     = a_reg;
    assign bus.b_out     = b_reg;
    assign bus.out_valid = valid_reg;
    assign bus.acc       = acc_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.res_out   = res_reg;
    assign bus.res_vout  = res_valid_reg;
endmodule

// File: tb/tb_pe_acc_drain.sv
// Bench for pe_acc_drain: a single 8b/32b PE, a 4-PE drain chain and an
// 8b/16b PE for overflow corners, all checked every cycle against an
// integer-arithmetic model, plus hand-computed literal expectations.
module tb_pe_acc_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    pe_acc_drain_if #(.DATA_W(8), .ACC_W(32)) if0 ();
    pe_acc_drain_if #(.DATA_W(8), .ACC_W(32)) ch_if [4] ();
    pe_acc_drain_if #(.DATA_W(8), .ACC_W(16)) if16 ();

    pe_acc_drain #(.DATA_W(8), .ACC_W(32)) u0   (.clk(clk), .rst(rst), .bus(if0));
    pe_acc_drain #(.DATA_W(8), .ACC_W(16)) u16  (.clk(clk), .rst(rst), .bus(if16));

    // Chain controls are shared; each PE gets its own west operand.
    logic       ch_clear, ch_sm, ch_iv, ch_load, ch_shift;
    logic [7:0] ch_a [4];
    logic [7:0] ch_b;
    logic [7:0]  ch_ao [4];
    logic [7:0]  ch_bo [4];
    logic        ch_ov [4];
    logic [31:0] ch_acc [4];
    logic        ch_ovf [4];
    logic [31:0] ch_ro [4];
    logic        ch_rv [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            assign ch_if[gi].clear       = ch_clear;
            assign ch_if[gi].signed_mode = ch_sm;
            assign ch_if[gi].in_valid    = ch_iv;
            assign ch_if[gi].a_in        = ch_a[gi];
            assign ch_if[gi].b_in        = ch_b;
            assign ch_if[gi].res_load    = ch_load;
            assign ch_if[gi].res_shift   = ch_shift;
            if (gi == 0) begin : g_head
                assign ch_if[gi].res_in  = '0;
                assign ch_if[gi].res_vin = 1'b0;
            end else begin : g_link
                assign ch_if[gi].res_in  = ch_if[gi-1].res_out;
                assign ch_if[gi].res_vin = ch_if[gi-1].res_vout;
            end
            assign ch_ao[gi]  = ch_if[gi].a_out;
            assign ch_bo[gi]  = ch_if[gi].b_out;
            assign ch_ov[gi]  = ch_if[gi].out_valid;
            assign ch_acc[gi] = ch_if[gi].acc;
            assign ch_ovf[gi] = ch_if[gi].ovf;
            assign ch_ro[gi]  = ch_if[gi].res_out;
            assign ch_rv[gi]  = ch_if[gi].res_vout;
            pe_acc_drain #(.DATA_W(8), .ACC_W(32)) u_pe (.clk(clk), .rst(rst), .bus(ch_if[gi]));
        end
    endgenerate

    // ---------------- behavioural model ----------------
    typedef struct {
        longint a_out; longint b_out; bit ov;
        longint acc;   bit ovf;       longint res; bit rv;
    } pe_st_t;
    typedef struct {
        bit clr; bit sm; bit iv; longint a; longint b;
        bit ld;  bit sh; longint rin; bit rvin;
    } pe_in_t;

    pe_st_t st [6];      // 0: u0, 1..4: chain PE0..PE3, 5: u16
    pe_st_t old_st [6];

    function automatic longint sx(longint v, int w);
        longint m = longint'(1) << w;
        return (v >= m / 2) ? v - m : v;
    endfunction

    // One clock of a PE expressed as plain integer arithmetic on the value range.
    function automatic pe_st_t pe_step(pe_st_t s, pe_in_t x, int w);
        pe_st_t n = s;
        longint m = longint'(1) << w;
        longint pa, pb, prod, cur, sum, lo, hi;
        n.a_out = x.a; n.b_out = x.b; n.ov = x.iv;
        pa = x.sm ? sx(x.a, 8) : x.a;
        pb = x.sm ? sx(x.b, 8) : x.b;
        prod = pa * pb;
        if (x.clr) begin
            n.ovf = 1'b0;
            n.acc = x.iv ? (((prod % m) + m) % m) : 0;
        end else if (x.iv) begin
            cur = x.sm ? sx(s.acc, w) : s.acc;
            sum = cur + prod;
            lo  = x.sm ? -(m / 2) : 0;
            hi  = x.sm ? (m / 2 - 1) : (m - 1);
            if (sum > hi || sum < lo) begin
                n.ovf = 1'b1;
`ifdef PE_SAT_EN
                sum = (sum > hi) ? hi : lo;
`endif
            end
            n.acc = ((sum % m) + m) % m;
        end
        if (x.ld) begin
            n.res = s.acc; n.rv = 1'b1;
        end else if (x.sh) begin
            n.res = x.rin; n.rv = x.rvin;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (st[i]) st[i] = '{default: 0};
        end else begin
            old_st = st;
            st[0] = pe_step(old_st[0], '{if0.clear, if0.signed_mode, if0.in_valid, if0.a_in, if0.b_in,
                                         if0.res_load, if0.res_shift, if0.res_in, if0.res_vin}, 32);
            for (int k = 0; k < 4; k++)
                st[k+1] = pe_step(old_st[k+1], '{ch_clear, ch_sm, ch_iv, ch_a[k], ch_b, ch_load, ch_shift,
                                                 (k == 0) ? 0 : old_st[k].res,
                                                 (k == 0) ? 1'b0 : old_st[k].rv}, 32);
            st[5] = pe_step(old_st[5], '{if16.clear, if16.signed_mode, if16.in_valid, if16.a_in, if16.b_in,
                                         if16.res_load, if16.res_shift, if16.res_in, if16.res_vin}, 16);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [63:0] act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(int i, logic [7:0] ao, logic [7:0] bo, logic ov, logic [31:0] ac,
                       logic of, logic [31:0] ro, logic rv);
        chk($sformatf("pe%0d.a_out", i),     ao, st[i].a_out);
        chk($sformatf("pe%0d.b_out", i),     bo, st[i].b_out);
        chk($sformatf("pe%0d.out_valid", i), ov, st[i].ov);
        chk($sformatf("pe%0d.acc", i),       ac, st[i].acc);
        chk($sformatf("pe%0d.ovf", i),       of, st[i].ovf);
        chk($sformatf("pe%0d.res_out", i),   ro, st[i].res);
        chk($sformatf("pe%0d.res_vout", i),  rv, st[i].rv);
    endtask

    // Every negedge: all outputs of all PEs against the model.
    always @(negedge clk) begin
        cmp(0, if0.a_out, if0.b_out, if0.out_valid, if0.acc, if0.ovf, if0.res_out, if0.res_vout);
        for (int k = 0; k < 4; k++)
            cmp(k + 1, ch_ao[k], ch_bo[k], ch_ov[k], ch_acc[k], ch_ovf[k], ch_ro[k], ch_rv[k]);
        cmp(5, if16.a_out, if16.b_out, if16.out_valid, 32'(if16.acc), if16.ovf,
            32'(if16.res_out), if16.res_vout);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note(string s);
        $display("[TB] step: %s", s);
    endtask

    task automatic u0_set(bit clr, bit sm, bit iv, logic [7:0] a, logic [7:0] b);
        if0.clear = clr; if0.signed_mode = sm; if0.in_valid = iv; if0.a_in = a; if0.b_in = b;
    endtask

    task automatic u16_set(bit clr, bit sm, bit iv, logic [7:0] a, logic [7:0] b);
        if16.clear = clr; if16.signed_mode = sm; if16.in_valid = iv; if16.a_in = a; if16.b_in = b;
    endtask

    initial begin
        u0_set(0, 0, 0, 0, 0);
        if0.res_load = 0; if0.res_shift = 0; if0.res_in = '0; if0.res_vin = 0;
        u16_set(0, 0, 0, 0, 0);
        if16.res_load = 0; if16.res_shift = 0; if16.res_in = '0; if16.res_vin = 0;
        ch_clear = 0; ch_sm = 0; ch_iv = 0; ch_load = 0; ch_shift = 0; ch_b = 0;
        for (int k = 0; k < 4; k++) ch_a[k] = 0;

        note("reset");
        tick(); tick();
        chk("reset.acc", if0.acc, 0);
        chk("reset.res_vout", if0.res_vout, 0);
        rst = 1'b0;

        note("signed clear+valid -3*4 then 2*7");
        u0_set(1, 1, 1, 8'hFD, 8'd4); tick();
        chk("t2.acc_first", if0.acc, longint'(32'hFFFF_FFF4));
        u0_set(0, 1, 1, 8'd2, 8'd7); tick();
        chk("t2.acc_second", if0.acc, 2);
        chk("t2.ovf", if0.ovf, 0);

        note("reset mid-run");
        rst = 1'b1; #1;
        chk("t1.acc_in_rst", if0.acc, 0);
        chk("t1.a_out_in_rst", if0.a_out, 0);
        chk("t1.out_valid_in_rst", if0.out_valid, 0);
        tick();
        rst = 1'b0;
        u0_set(0, 0, 1, 8'd5, 8'd0); tick();
        chk("t1.a_out", if0.a_out, 5);
        chk("t1.out_valid", if0.out_valid, 1);

        note("unsigned 255*255 x3");
        u0_set(1, 0, 1, 8'hFF, 8'hFF); tick();
        u0_set(0, 0, 1, 8'hFF, 8'hFF); tick(); tick();
        chk("t3.unsigned_acc", if0.acc, 195075);
        note("signed same bits x3");
        u0_set(1, 1, 1, 8'hFF, 8'hFF); tick();
        u0_set(0, 1, 1, 8'hFF, 8'hFF); tick(); tick();
        chk("t3.signed_acc", if0.acc, 3);

        note("invalid operands ignored");
        u0_set(0, 1, 0, 8'd9, 8'd9);
        repeat (4) tick();
        chk("t4.acc_hold", if0.acc, 3);
        chk("t4.out_valid", if0.out_valid, 0);

        note("single PE load / shift / load+shift");
        if0.res_load = 1; tick();
        chk("drain.load", if0.res_out, 3);
        chk("drain.load_v", if0.res_vout, 1);
        if0.res_load = 0; if0.res_shift = 1; if0.res_in = 32'd77; if0.res_vin = 0; tick();
        chk("drain.shift", if0.res_out, 77);
        chk("drain.shift_v", if0.res_vout, 0);
        if0.res_load = 1; if0.res_in = 32'd99; tick();
        chk("drain.load_wins", if0.res_out, 3);
        if0.res_load = 0; if0.res_shift = 0;

        note("chain tile accumulate 10/20/30/40");
        ch_clear = 1; ch_iv = 1; ch_b = 8'd1;
        for (int k = 0; k < 4; k++) ch_a[k] = 8'(10 * (k + 1));
        tick();
        note("chain load+clear, new tile starts");
        ch_load = 1;
        for (int k = 0; k < 4; k++) ch_a[k] = 8'd1;
        tick();
        chk("t5.edge0", ch_ro[3], 40);
        chk("t5.edge0_v", ch_rv[3], 1);
        ch_load = 0; ch_clear = 0; ch_shift = 1;
        tick(); note("chain shift 1"); chk("t5.edge1", ch_ro[3], 30);
        tick(); note("chain shift 2"); chk("t5.edge2", ch_ro[3], 20);
        tick(); note("chain shift 3"); chk("t5.edge3", ch_ro[3], 10);
        tick(); note("chain shift 4");
        chk("t5.edge_v_after", ch_rv[3], 0);
        chk("t5.new_tile_acc0", ch_acc[0], 5);
        chk("t5.new_tile_acc3", ch_acc[3], 5);
        ch_shift = 0; ch_iv = 0;

        note("16-bit signed ramp to 32767");
        u16_set(1, 1, 1, 8'd127, 8'd127); tick();
        u16_set(0, 1, 1, 8'd127, 8'd127); tick();
        u16_set(0, 1, 1, 8'd127, 8'd4);   tick();
        u16_set(0, 1, 1, 8'd1,   8'd1);   tick();
        chk("t6.acc_max", if16.acc, 32767);
        chk("t6.ovf_before", if16.ovf, 0);
        note("16-bit signed add 1 past max");
        tick();
`ifdef PE_SAT_EN
        chk("t6.acc_ovf", if16.acc, 32767);
`else
        chk("t6.acc_ovf", if16.acc, 32768);
`endif
        chk("t6.ovf_set", if16.ovf, 1);
        note("16-bit clear");
        u16_set(1, 1, 0, 8'd0, 8'd0); tick();
        chk("t6.ovf_cleared", if16.ovf, 0);
        chk("t6.acc_cleared", if16.acc, 0);

        note("16-bit unsigned carry out");
        u16_set(1, 0, 1, 8'hFF, 8'hFF); tick();
        u16_set(0, 0, 1, 8'hFF, 8'hFF); tick();
`ifdef PE_SAT_EN
        chk("t6.unsigned_ovf_acc", if16.acc, 65535);
`else
        chk("t6.unsigned_ovf_acc", if16.acc, 64514);
`endif
        chk("t6.unsigned_ovf", if16.ovf, 1);

        note("16-bit signed negative overflow");
        u16_set(1, 1, 1, 8'h80, 8'd127); tick();
        u16_set(0, 1, 1, 8'h80, 8'd127); tick(); tick();
`ifdef PE_SAT_EN
        chk("t6.neg_ovf_acc", if16.acc, 32768);
`else
        chk("t6.neg_ovf_acc", if16.acc, 16768);
`endif
        chk("t6.neg_ovf", if16.ovf, 1);
        u16_set(0, 1, 0, 8'd0, 8'd0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
